xor_t: RTL and testbench

Bitwise XOR unit of the floating-point module; computes the product sign (sign_a ^ sign_b) for the multiplier and serves as a generic operand-difference detector. It provides a zero-latency combinational result for the sign path plus a registered, valid-qualified copy with a Hamming-distance count for pipelined consumers. One clock domain, asynchronous active-low reset.

---
 rtl/xor_t_pkg.sv | 23 ++
 rtl/xor_t_if.sv | 29 ++
 rtl/xor_pipe_stage.sv | 63 ++++++
 rtl/xor_t.sv | 52 +++++
 tb/tb_xor_t.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/xor_t_pkg.sv
// Shared fp helpers: sign-path width and a popcount reused by the normaliser.
// Pure declarations, no logic of its own.
package xor_t_pkg;

    localparam int SIGN_W    = 1;
    localparam int POP_IN_W  = 64;
    localparam int POP_OUT_W = 7;

    // Difference-counter width for a WIDTH-bit operand, never below one bit.
    function automatic int cnt_w(input int width);
        return (width < 1) ? 1 : $clog2(width + 1);
    endfunction

    function automatic logic [POP_OUT_W-1:0] popcount(input logic [POP_IN_W-1:0] word);
        logic [POP_OUT_W-1:0] n;
        n = '0;
        for (int i = 0; i < POP_IN_W; i++) begin
            n = n + POP_OUT_W'(word[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/xor_t_if.sv
// Operand/result bundle for xor_t: master drives operands, slave returns
// the combinational and pipelined results.
interface xor_t_if
    import xor_t_pkg::*;
#(
    parameter int WIDTH = SIGN_W
);
    localparam int CNT_W = cnt_w(WIDTH);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_valid;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] c_q;
    logic             out_valid;
    logic [CNT_W-1:0] diff_cnt;
    logic             any_diff;

    modport master (
        output a, b, in_valid,
        input  c, c_q, out_valid, diff_cnt, any_diff
    );

    modport slave (
        input  a, b, in_valid,
        output c, c_q, out_valid, diff_cnt, any_diff
    );

endinterface

// File: rtl/xor_pipe_stage.sv
// One register stage carrying valid + data, 1-cycle latency, no backpressure.
// The last stage also registers popcount/any-diff of its input so they line up with the data.
module xor_pipe_stage
    import xor_t_pkg::*;
#(
    parameter int WIDTH = SIGN_W,
    parameter int CNT_W = 1,
    parameter bit LAST  = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_dat,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_dat,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_any
);

    logic             r_vld;
    logic [WIDTH-1:0] r_dat;

    // Data loads every cycle; consumers qualify with the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else begin
            r_vld <= i_vld;
            r_dat <= i_dat;
        end
    end

    assign o_vld = r_vld;
    assign o_dat = r_dat;

    generate
        if (LAST) begin : g_stat
            logic [CNT_W-1:0] w_cnt;
            logic [CNT_W-1:0] r_cnt;
            logic             r_any;

            assign w_cnt = CNT_W'(popcount(POP_IN_W'(i_dat)));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                    r_any <= 1'b0;
                end else begin
                    r_cnt <= w_cnt;
                    r_any <= |i_dat;
                end
            end

            assign o_cnt = r_cnt;
            assign o_any = r_any;
        end else begin : g_pass
            assign o_cnt = '0;
            assign o_any = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/xor_t.sv
// Bitwise XOR: zero-latency c = a ^ b plus a STAGES-deep registered copy with
// Hamming count; no backpressure, the pipe advances every cycle.
module xor_t
    import xor_t_pkg::*;
#(
    parameter int WIDTH  = SIGN_W,
    parameter int STAGES = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    xor_t_if.slave bus
);

    localparam int CNT_W = cnt_w(WIDTH);

    logic [WIDTH-1:0] w_x;
    logic             w_vld [STAGES+1];
    logic [WIDTH-1:0] w_dat [STAGES+1];
    logic [CNT_W-1:0] w_cnt [STAGES];
    logic             w_any [STAGES];

    // Sign path stays outside the pipe so it is live even while in reset.
    assign w_x      = bus.a ^ bus.b;
    assign bus.c    = w_x;
    assign w_vld[0] = bus.in_valid;
    assign w_dat[0] = w_x;

    generate
        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            xor_pipe_stage #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W),
                .LAST  (i == STAGES - 1)
            ) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .i_vld (w_vld[i]),
                .i_dat (w_dat[i]),
                .o_vld (w_vld[i+1]),
                .o_dat (w_dat[i+1]),
                .o_cnt (w_cnt[i]),
                .o_any (w_any[i])
            );
        end
    endgenerate

    assign bus.c_q       = w_dat[STAGES];
    assign bus.out_valid = w_vld[STAGES];
    assign bus.diff_cnt  = w_cnt[STAGES-1];
    assign bus.any_diff  = w_any[STAGES-1];

endmodule

// File: tb/tb_xor_t.sv
// Directed checks of xor_t across several WIDTH/STAGES instances.
module tb_xor_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    xor_t_if #(.WIDTH(1))  if1  ();
    xor_t_if #(.WIDTH(8))  if8a ();
    xor_t_if #(.WIDTH(8))  if8b ();
    xor_t_if #(.WIDTH(8))  if8c ();
    xor_t_if #(.WIDTH(32)) if32 ();

    xor_t #(.WIDTH(1),  .STAGES(1)) u1   (.clk(clk), .rst_n(rst_n), .bus(if1));
    xor_t #(.WIDTH(8),  .STAGES(1)) u8a  (.clk(clk), .rst_n(rst_n), .bus(if8a));
    xor_t #(.WIDTH(8),  .STAGES(2)) u8b  (.clk(clk), .rst_n(rst_n), .bus(if8b));
    xor_t #(.WIDTH(8),  .STAGES(3)) u8c  (.clk(clk), .rst_n(rst_n), .bus(if8c));
    xor_t #(.WIDTH(32), .STAGES(1)) u32  (.clk(clk), .rst_n(rst_n), .bus(if32));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        vld;
        logic [31:0] exp_c;
        logic [31:0] exp_q;
        int          exp_cnt;
        logic        exp_any;
        logic        exp_vld;
    } vec_t;

    int total = 0;
    int bad   = 0;

    vec_t t1 [4];
    vec_t t8 [6];
    vec_t t2 [5];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic vld,
                                input logic [31:0] c, input logic [31:0] q, input int cnt,
                                input logic any, input logic ovld);
        vec_t v;
        v.a = a; v.b = b; v.vld = vld; v.exp_c = c; v.exp_q = q;
        v.exp_cnt = cnt; v.exp_any = any; v.exp_vld = ovld;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        if1.a  = '0; if1.b  = '0; if1.in_valid  = 1'b0;
        if8a.a = '0; if8a.b = '0; if8a.in_valid = 1'b0;
        if8b.a = '0; if8b.b = '0; if8b.in_valid = 1'b0;
        if8c.a = '0; if8c.b = '0; if8c.in_valid = 1'b0;
        if32.a = '0; if32.b = '0; if32.in_valid = 1'b0;

        t1[0] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        t1[1] = mk(1, 0, 0, 1, 0, 0, 0, 0);
        t1[2] = mk(0, 1, 0, 1, 0, 0, 0, 0);
        t1[3] = mk(1, 1, 0, 0, 0, 0, 0, 0);

        // WIDTH=8, STAGES=1: expectations are the outputs after one edge
        t8[0] = mk(32'hF0, 32'h3C, 1, 32'hCC, 32'hCC, 4, 1, 1);
        t8[1] = mk(32'hA5, 32'hA5, 1, 32'h00, 32'h00, 0, 0, 1);
        t8[2] = mk(32'hFF, 32'h00, 1, 32'hFF, 32'hFF, 8, 1, 1);
        t8[3] = mk(32'h55, 32'hAA, 0, 32'hFF, 32'hFF, 8, 1, 0);
        t8[4] = mk(32'h80, 32'h81, 1, 32'h01, 32'h01, 1, 1, 1);
        t8[5] = mk(32'h00, 32'h00, 0, 32'h00, 32'h00, 0, 0, 0);

        // STAGES=2 alternating valids: exp_q is what sits at the output after this edge
        t2[0] = mk(32'h11, 32'h22, 1, 32'h33, 32'h00, 0, 0, 0);
        t2[1] = mk(32'h0F, 32'hF0, 0, 32'hFF, 32'h33, 4, 1, 1);
        t2[2] = mk(32'h12, 32'h34, 1, 32'h26, 32'hFF, 8, 1, 0);
        t2[3] = mk(32'h00, 32'h00, 0, 32'h00, 32'h26, 3, 1, 1);
        t2[4] = mk(32'h00, 32'h00, 0, 32'h00, 32'h00, 0, 0, 0);

        #2 rst_n = 1'b0;
        #1;
        chk("rst_c_q",       64'(if8c.c_q),       64'h0);
        chk("rst_out_valid", 64'(if8c.out_valid), 64'h0);
        chk("rst_diff_cnt",  64'(if32.diff_cnt),  64'h0);
        chk("rst_any_diff",  64'(if8a.any_diff),  64'h0);

        // Combinational sign path, exercised while the pipe is held in reset
        for (int i = 0; i < 4; i++) begin
            if1.a = t1[i].a[0];
            if1.b = t1[i].b[0];
            #1;
            chk("w1_c", 64'(if1.c), 64'(t1[i].exp_c));
            #99;
        end
        chk("w1_rst_c_q", 64'(if1.c_q), 64'h0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            if8a.a = t8[i].a[7:0];
            if8a.b = t8[i].b[7:0];
            if8a.in_valid = t8[i].vld;
            #1;
            chk("s1_c", 64'(if8a.c), 64'(t8[i].exp_c));
            step();
            chk("s1_c_q",  64'(if8a.c_q),       64'(t8[i].exp_q));
            chk("s1_cnt",  64'(if8a.diff_cnt),  64'(t8[i].exp_cnt));
            chk("s1_any",  64'(if8a.any_diff),  64'(t8[i].exp_any));
            chk("s1_vld",  64'(if8a.out_valid), 64'(t8[i].exp_vld));
        end

        // STAGES=3, equal operands: zero difference after exactly three edges
        if8c.a = 8'hA5; if8c.b = 8'hA5; if8c.in_valid = 1'b1;
        step();
        chk("s3_vld_e1", 64'(if8c.out_valid), 64'h0);
        if8c.in_valid = 1'b0;
        step();
        chk("s3_vld_e2", 64'(if8c.out_valid), 64'h0);
        step();
        chk("s3_vld_e3", 64'(if8c.out_valid), 64'h1);
        chk("s3_c_q",    64'(if8c.c_q),       64'h0);
        chk("s3_cnt",    64'(if8c.diff_cnt),  64'h0);
        chk("s3_any",    64'(if8c.any_diff),  64'h0);
        step();
        chk("s3_vld_e4", 64'(if8c.out_valid), 64'h0);

        for (int i = 0; i < 5; i++) begin
            if8b.a = t2[i].a[7:0];
            if8b.b = t2[i].b[7:0];
            if8b.in_valid = t2[i].vld;
            step();
            chk("s2_c_q", 64'(if8b.c_q),       64'(t2[i].exp_q));
            chk("s2_cnt", 64'(if8b.diff_cnt),  64'(t2[i].exp_cnt));
            chk("s2_any", 64'(if8b.any_diff),  64'(t2[i].exp_any));
            chk("s2_vld", 64'(if8b.out_valid), 64'(t2[i].exp_vld));
        end

        // Full-width difference on 32 bits needs the whole 6-bit counter
        if32.a = 32'hFFFF_FFFF; if32.b = 32'h0; if32.in_valid = 1'b1;
        #1;
        chk("w32_c", 64'(if32.c), 64'hFFFF_FFFF);
        step();
        chk("w32_cnt", 64'(if32.diff_cnt),  64'd32);
        chk("w32_c_q", 64'(if32.c_q),       64'hFFFF_FFFF);
        chk("w32_any", 64'(if32.any_diff),  64'h1);
        chk("w32_vld", 64'(if32.out_valid), 64'h1);
        if32.in_valid = 1'b0;

        if1.a = 1'b1; if1.b = 1'b0; if1.in_valid = 1'b1;
        step();
        chk("w1_c_q", 64'(if1.c_q),       64'h1);
        chk("w1_cnt", 64'(if1.diff_cnt),  64'h1);
        chk("w1_vld", 64'(if1.out_valid), 64'h1);
        if1.in_valid = 1'b0;

        // Reset while the 3-stage pipe is full
        if8c.a = 8'hFF; if8c.b = 8'h00; if8c.in_valid = 1'b1;
        step(); step(); step();
        chk("pre_rst_vld", 64'(if8c.out_valid), 64'h1);
        chk("pre_rst_c_q", 64'(if8c.c_q),       64'hFF);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_c_q", 64'(if8c.c_q),       64'h0);
        chk("mid_rst_vld", 64'(if8c.out_valid), 64'h0);
        chk("mid_rst_cnt", 64'(if8c.diff_cnt),  64'h0);
        chk("mid_rst_any", 64'(if8c.any_diff),  64'h0);
        if8c.a = 8'h0F; if8c.b = 8'h00;
        #1;
        chk("mid_rst_c", 64'(if8c.c), 64'h0F);
        step();
        chk("held_rst_vld", 64'(if8c.out_valid), 64'h0);

        rst_n = 1'b1;
        if8c.a = 8'h3C; if8c.b = 8'h00; if8c.in_valid = 1'b1;
        step();
        chk("post_rst_vld_e1", 64'(if8c.out_valid), 64'h0);
        if8c.in_valid = 1'b0;
        step();
        chk("post_rst_vld_e2", 64'(if8c.out_valid), 64'h0);
        step();
        chk("post_rst_vld_e3", 64'(if8c.out_valid), 64'h1);
        chk("post_rst_c_q",    64'(if8c.c_q),       64'h3C);
        chk("post_rst_cnt",    64'(if8c.diff_cnt),  64'h4);
        chk("post_rst_any",    64'(if8c.any_diff),  64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
